// File: rtl/bypass_controller_pkg.sv
// Shared flit-format definitions and FSM state types for bypass_controller.
// DATA_WIDTH defaults to 32 when not already defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package bypass_controller_pkg;

    localparam int DW      = `DATA_WIDTH;
    localparam int TYPE_HI = DW - 1;
    localparam int TYPE_LO = DW - 2;
    localparam int DEST_HI = DW - 3;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic [1:0] {E_IDLE, E_RT, E_BP} eg_state_e;
    typedef enum logic [1:0] {I_IDLE, I_RT, I_BP} in_state_e;

    function automatic logic [1:0] flit_type(input logic [DW-1:0] f);
        return f[TYPE_HI:TYPE_LO];
    endfunction

    // Head or single: the flit opens a packet.
    function automatic logic is_start(input logic [DW-1:0] f);
        return (flit_type(f) == FLIT_HEAD) || (flit_type(f) == FLIT_SINGLE);
    endfunction

    // Tail or single: the flit closes a packet.
    function automatic logic is_last(input logic [DW-1:0] f);
        return (flit_type(f) == FLIT_TAIL) || (flit_type(f) == FLIT_SINGLE);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
    endfunction

endpackage

// File: rtl/bypass_controller_arb.sv
// pkt_arbiter2: two-source wormhole arbiter with round-robin pointer.
// Source 0 is the router, source 1 the bypass input.
module pkt_arbiter2
    import bypass_controller_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0][DW-1:0]  req_data_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    output logic [DW-1:0]       out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);

    eg_state_e state_q, state_d;
    logic      ptr_q, ptr_d;
    logic      sel;
    logic [1:0] elig;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= E_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel         = 1'b0;
        out_valid_o = 1'b0;
        req_ready_o = '0;
        for (int i = 0; i < 2; i++)
            elig[i] = req_valid_i[i] && is_start(req_data_i[i]);

        case (state_q)
            E_IDLE: begin
                // Grant is recomputed every cycle until the opening flit moves.
                if (|elig) begin
                    sel              = (&elig) ? ptr_q : elig[1];
                    out_valid_o      = 1'b1;
                    req_ready_o[sel] = out_ready_i;
                    if (out_ready_i) begin
                        ptr_d = ~sel;
                        if (flit_type(req_data_i[sel]) == FLIT_HEAD)
                            state_d = sel ? E_BP : E_RT;
                    end
                end
            end
            E_RT: begin
                sel            = 1'b0;
                out_valid_o    = req_valid_i[0];
                req_ready_o[0] = out_ready_i;
                if (req_valid_i[0] && out_ready_i &&
                    flit_type(req_data_i[0]) == FLIT_TAIL)
                    state_d = E_IDLE;
            end
            E_BP: begin
                sel            = 1'b1;
                out_valid_o    = req_valid_i[1];
                req_ready_o[1] = out_ready_i;
                if (req_valid_i[1] && out_ready_i &&
                    flit_type(req_data_i[1]) == FLIT_TAIL)
                    state_d = E_IDLE;
            end
            default: state_d = E_IDLE;
        endcase

        out_data_o = req_data_i[sel];
    end

endmodule

// File: rtl/bypass_controller.sv
// Router/bypass <-> sync_controller packet switch: egress arbiter plus ingress demux.
// Optional `BYPASS_CNT_EN adds saturating completed-packet counters.
module bypass_controller
    import bypass_controller_pkg::*;
#(
    parameter int LOCAL_ID = 0,
    parameter int ID_W     = 4
) (
    input  logic                   CDCLK,
    input  logic                   CDRESETn,
    input  logic [`DATA_WIDTH-1:0] RTIDATA,
    input  logic                   RTIVALID,
    output logic                   RTIREADY,
    input  logic [`DATA_WIDTH-1:0] BPIDATA,
    input  logic                   BPIVALID,
    output logic                   BPIREADY,
    output logic [`DATA_WIDTH-1:0] OUTDATA,
    output logic                   OUTVALID,
    input  logic                   OUTREADY,
    input  logic [`DATA_WIDTH-1:0] INDATA,
    input  logic                   INVALID,
    output logic                   INREADY,
    output logic [`DATA_WIDTH-1:0] RTODATA,
    output logic                   RTOVALID,
    input  logic                   RTOREADY,
    output logic [`DATA_WIDTH-1:0] BPODATA,
    output logic                   BPOVALID,
    input  logic                   BPOREADY
`ifdef BYPASS_CNT_EN
    ,
    output logic [15:0]            CNT_RT,
    output logic [15:0]            CNT_BP,
    output logic [15:0]            CNT_EG
`endif
);

    localparam logic [ID_W-1:0] LOCAL_ID_C = ID_W'(LOCAL_ID);

    logic [1:0] arb_ready;

    pkt_arbiter2 u_arb (
        .clk_i       (CDCLK),
        .rst_ni      (CDRESETn),
        .req_data_i  ({BPIDATA, RTIDATA}),
        .req_valid_i ({BPIVALID, RTIVALID}),
        .req_ready_o (arb_ready),
        .out_data_o  (OUTDATA),
        .out_valid_o (OUTVALID),
        .out_ready_i (OUTREADY)
    );

    assign RTIREADY = arb_ready[0];
    assign BPIREADY = arb_ready[1];

    in_state_e in_state_q, in_state_d;
    logic      drop;
    logic      to_local;
    // Simulation-visible pulse for body/tail flits discarded outside a packet.
    logic      drop_err_unused_q;

    assign RTODATA  = INDATA;
    assign BPODATA  = INDATA;
    assign to_local = (INDATA[DEST_HI -: ID_W] == LOCAL_ID_C);

    always_ff @(posedge CDCLK or negedge CDRESETn) begin
        if (!CDRESETn) begin
            in_state_q        <= I_IDLE;
            drop_err_unused_q <= 1'b0;
        end else begin
            in_state_q        <= in_state_d;
            drop_err_unused_q <= drop;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        RTOVALID   = 1'b0;
        BPOVALID   = 1'b0;
        INREADY    = 1'b0;
        drop       = 1'b0;
        case (in_state_q)
            I_IDLE: begin
                if (INVALID) begin
                    if (!is_start(INDATA)) begin
                        INREADY = 1'b1;
                        drop    = 1'b1;
                    end else if (to_local) begin
                        RTOVALID = 1'b1;
                        INREADY  = RTOREADY;
                        if (RTOREADY && flit_type(INDATA) == FLIT_HEAD)
                            in_state_d = I_RT;
                    end else begin
                        BPOVALID = 1'b1;
                        INREADY  = BPOREADY;
                        if (BPOREADY && flit_type(INDATA) == FLIT_HEAD)
                            in_state_d = I_BP;
                    end
                end
            end
            I_RT: begin
                RTOVALID = INVALID;
                INREADY  = RTOREADY;
                if (INVALID && RTOREADY && flit_type(INDATA) == FLIT_TAIL)
                    in_state_d = I_IDLE;
            end
            I_BP: begin
                BPOVALID = INVALID;
                INREADY  = BPOREADY;
                if (INVALID && BPOREADY && flit_type(INDATA) == FLIT_TAIL)
                    in_state_d = I_IDLE;
            end
            default: in_state_d = I_IDLE;
        endcase
    end

`ifdef BYPASS_CNT_EN
    logic [15:0] cnt_rt_q, cnt_bp_q, cnt_eg_q;

    always_ff @(posedge CDCLK or negedge CDRESETn) begin
        if (!CDRESETn) begin
            cnt_rt_q <= '0;
            cnt_bp_q <= '0;
            cnt_eg_q <= '0;
        end else begin
            cnt_rt_q <= sat_inc(cnt_rt_q, RTOVALID && RTOREADY && is_last(RTODATA));
            cnt_bp_q <= sat_inc(cnt_bp_q, BPOVALID && BPOREADY && is_last(BPODATA));
            cnt_eg_q <= sat_inc(cnt_eg_q, OUTVALID && OUTREADY && is_last(OUTDATA));
        end
    end

    assign CNT_RT = cnt_rt_q;
    assign CNT_BP = cnt_bp_q;
    assign CNT_EG = cnt_eg_q;
`endif

endmodule

// File: tb/tb_bypass_controller.sv
// Directed bench for bypass_controller; inputs change 2 time units after each
// rising edge and outputs are compared 1 unit later.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_bypass_controller;

    localparam int DW  = `DATA_WIDTH;
    localparam int LID = 2;

    logic          CDCLK = 1'b0;
    logic          CDRESETn;
    logic [DW-1:0] RTIDATA, BPIDATA, INDATA;
    logic          RTIVALID, BPIVALID, INVALID;
    logic          OUTREADY, RTOREADY, BPOREADY;
    logic          RTIREADY, BPIREADY, INREADY;
    logic [DW-1:0] OUTDATA, RTODATA, BPODATA;
    logic          OUTVALID, RTOVALID, BPOVALID;
`ifdef BYPASS_CNT_EN
    logic [15:0]   CNT_RT, CNT_BP, CNT_EG;
`endif

    int nchk = 0;
    int nerr = 0;

    always #5 CDCLK = ~CDCLK;

    bypass_controller #(.LOCAL_ID(LID), .ID_W(4)) dut (
        .CDCLK(CDCLK), .CDRESETn(CDRESETn),
        .RTIDATA(RTIDATA), .RTIVALID(RTIVALID), .RTIREADY(RTIREADY),
        .BPIDATA(BPIDATA), .BPIVALID(BPIVALID), .BPIREADY(BPIREADY),
        .OUTDATA(OUTDATA), .OUTVALID(OUTVALID), .OUTREADY(OUTREADY),
        .INDATA(INDATA), .INVALID(INVALID), .INREADY(INREADY),
        .RTODATA(RTODATA), .RTOVALID(RTOVALID), .RTOREADY(RTOREADY),
        .BPODATA(BPODATA), .BPOVALID(BPOVALID), .BPOREADY(BPOREADY)
`ifdef BYPASS_CNT_EN
        , .CNT_RT(CNT_RT), .CNT_BP(CNT_BP), .CNT_EG(CNT_EG)
`endif
    );

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [3:0] d, input int p);
        logic [DW-7:0] pl;
        pl = p[DW-7:0];
        return {t, d, pl};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CDCLK);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        CDRESETn = 1'b0;
        #3;
        CDRESETn = 1'b1;
    endtask

    logic [DW-1:0] hA, bA, tA, hB, tB, sA, sB, f0, f1, f2;

    initial begin
        CDRESETn = 1'b0;
        RTIDATA = '0; BPIDATA = '0; INDATA = '0;
        RTIVALID = 0; BPIVALID = 0; INVALID = 0;
        OUTREADY = 0; RTOREADY = 0; BPOREADY = 0;
        hA = mk(2'b01, 4'd5, 'h111); bA = mk(2'b00, 4'd5, 'h112); tA = mk(2'b10, 4'd5, 'h113);
        hB = mk(2'b01, 4'd6, 'h221); tB = mk(2'b10, 4'd6, 'h223);
        sA = mk(2'b11, 4'd1, 'h331); sB = mk(2'b11, 4'd1, 'h441);

        // Reset state with idle inputs
        step(); settle();
        chk("rst_outvalid", OUTVALID, 0);
        chk("rst_rtivalid_rdy", RTIREADY, 0);
        chk("rst_bpiready", BPIREADY, 0);
        chk("rst_inready", INREADY, 0);
        chk("rst_rtovalid", RTOVALID, 0);
        chk("rst_bpovalid", BPOVALID, 0);
        #1; CDRESETn = 1'b1;

        // Router packet alone, OUTREADY high
        step(); OUTREADY = 1; RTIVALID = 1; RTIDATA = hA; settle();
        chk("t1_head_data", OUTDATA, hA); chk("t1_head_valid", OUTVALID, 1);
        chk("t1_head_rdy", RTIREADY, 1);  chk("t1_head_bprdy", BPIREADY, 0);
        step(); RTIDATA = bA; settle();
        chk("t1_body_data", OUTDATA, bA); chk("t1_body_rdy", RTIREADY, 1);
        step(); RTIDATA = tA; settle();
        chk("t1_tail_data", OUTDATA, tA); chk("t1_tail_rdy", RTIREADY, 1);
        // Back in idle: a stray body flit is blocked, not forwarded
        step(); RTIVALID = 0; BPIVALID = 1; BPIDATA = mk(2'b00, 4'd0, 'h55); settle();
        chk("t1_idle_body_valid", OUTVALID, 0); chk("t1_idle_body_rdy", BPIREADY, 0);
        BPIVALID = 0;

        // Both heads together after reset: router first, no interleave
        step(); do_reset();
        step(); RTIVALID = 1; RTIDATA = hA; BPIVALID = 1; BPIDATA = hB; settle();
        chk("t2_hA", OUTDATA, hA); chk("t2_hA_rt", RTIREADY, 1); chk("t2_hA_bp", BPIREADY, 0);
        step(); RTIDATA = bA; settle();
        chk("t2_bA", OUTDATA, bA); chk("t2_bA_bp", BPIREADY, 0);
        step(); RTIDATA = tA; settle();
        chk("t2_tA", OUTDATA, tA); chk("t2_tA_bp", BPIREADY, 0);
        step(); RTIVALID = 0; settle();
        chk("t2_hB", OUTDATA, hB); chk("t2_hB_bp", BPIREADY, 1); chk("t2_hB_rt", RTIREADY, 0);
        step(); BPIDATA = tB; settle();
        chk("t2_tB", OUTDATA, tB); chk("t2_tB_bp", BPIREADY, 1);

        // Non-sticky grant and round robin with singles (pointer now at router)
        step(); OUTREADY = 0; RTIVALID = 1; RTIDATA = sA; BPIDATA = sB; settle();
        chk("t3_stall_data", OUTDATA, sA); chk("t3_stall_valid", OUTVALID, 1);
        chk("t3_stall_rt", RTIREADY, 0); chk("t3_stall_bp", BPIREADY, 0);
        step(); OUTREADY = 1; RTIVALID = 0; settle();
        chk("t3_bp_only", OUTDATA, sB); chk("t3_bp_only_rdy", BPIREADY, 1);
        step(); RTIVALID = 1; BPIVALID = 0; settle();
        chk("t3_rt_only", OUTDATA, sA); chk("t3_rt_only_rdy", RTIREADY, 1);
        step(); BPIVALID = 1; settle();
        chk("t3_rr_bp", OUTDATA, sB); chk("t3_rr_bp_rdy", BPIREADY, 1); chk("t3_rr_bp_rt", RTIREADY, 0);
        step(); settle();
        chk("t3_rr_rt", OUTDATA, sA); chk("t3_rr_rt_rdy", RTIREADY, 1); chk("t3_rr_rt_bp", BPIREADY, 0);
        step(); RTIVALID = 0; BPIVALID = 0;

        // Ingress: local single to router, remote packet to bypass with stall
        RTOREADY = 1; BPOREADY = 1;
        f0 = mk(2'b11, 4'(LID), 'h601);
        f1 = mk(2'b01, 4'(LID + 1), 'h602);
        f2 = mk(2'b00, 4'(LID + 1), 'h603);
        INVALID = 1; INDATA = f0; settle();
        chk("t4_single_rtov", RTOVALID, 1); chk("t4_single_bpov", BPOVALID, 0);
        chk("t4_single_inrdy", INREADY, 1); chk("t4_single_data", RTODATA, f0);
        step(); INDATA = f1; settle();
        chk("t4_head_bpov", BPOVALID, 1); chk("t4_head_rtov", RTOVALID, 0);
        chk("t4_head_inrdy", INREADY, 1);
        step(); INDATA = f2; BPOREADY = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t4_stall_inrdy", INREADY, 0); chk("t4_stall_bpov", BPOVALID, 1);
            chk("t4_stall_data", BPODATA, f2); chk("t4_stall_rtov", RTOVALID, 0);
            step();
        end
        BPOREADY = 1; settle();
        chk("t4_resume_inrdy", INREADY, 1); chk("t4_resume_data", BPODATA, f2);
        step(); INDATA = mk(2'b10, 4'(LID), 'h604); settle();
        chk("t4_tail_bpov", BPOVALID, 1); chk("t4_tail_rtov", RTOVALID, 0);
        chk("t4_tail_inrdy", INREADY, 1);
        // Idle again: a body flit is dropped
        step(); INDATA = mk(2'b00, 4'(LID), 'h605); settle();
        chk("t4_drop_inrdy", INREADY, 1); chk("t4_drop_rtov", RTOVALID, 0);
        chk("t4_drop_bpov", BPOVALID, 0);
        step(); INVALID = 0;

        // Reset after the head of an egress packet
        RTIVALID = 1; RTIDATA = hA; settle();
        chk("t5_head_rdy", RTIREADY, 1);
        step(); RTIDATA = bA; settle();
        chk("t5_locked_valid", OUTVALID, 1);
        CDRESETn = 1'b0; #1;
        chk("t5_rst_outvalid", OUTVALID, 0); chk("t5_rst_rtirdy", RTIREADY, 0);
        #1; CDRESETn = 1'b1;
        step(); RTIVALID = 0; BPIVALID = 1; BPIDATA = sB; settle();
        chk("t5_bp_single", OUTDATA, sB); chk("t5_bp_single_valid", OUTVALID, 1);
        chk("t5_bp_single_rdy", BPIREADY, 1);
        step(); BPIVALID = 0;

`ifdef BYPASS_CNT_EN
        do_reset();
        settle();
        chk("c_rst_rt", CNT_RT, 0);
        INVALID = 1; INDATA = mk(2'b11, 4'(LID), 'h777); RTOREADY = 1;
        repeat (70000) @(posedge CDCLK);
        #2; INVALID = 0; settle();
        chk("c_sat_rt", CNT_RT, 16'hFFFF); chk("c_bp", CNT_BP, 0); chk("c_eg", CNT_EG, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
